// File: rtl/alu_rs_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : alu_rs_scheduler
// Brief    : ALU reservation station. Snoops two CDBs for operand wakeup and
//            issues the lowest-index ready entry to the ALU each cycle.
// Revision : 1.0
// ============================================================================
module alu_rs_scheduler #(
    parameter int RS_SIZE_BIT   = 3,
    parameter int ROB_WIDTH_BIT = 3,
    parameter int TYPE_BIT      = 5
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [TYPE_BIT-1:0]      in_type,
    input  logic [31:0]              in_v1,
    input  logic                     in_has_dep1,
    input  logic [ROB_WIDTH_BIT-1:0] in_q1,
    input  logic [31:0]              in_v2,
    input  logic                     in_has_dep2,
    input  logic [ROB_WIDTH_BIT-1:0] in_q2,
    input  logic [ROB_WIDTH_BIT-1:0] in_rob_id,
    output logic                     full,
    input  logic                     alu_cdb_ready,
    input  logic [ROB_WIDTH_BIT-1:0] alu_cdb_rob_id,
    input  logic [31:0]              alu_cdb_value,
    input  logic                     lsb_cdb_ready,
    input  logic [ROB_WIDTH_BIT-1:0] lsb_cdb_rob_id,
    input  logic [31:0]              lsb_cdb_value,
    output logic                     issue_valid,
    output logic [TYPE_BIT-1:0]      issue_type,
    output logic [31:0]              issue_r1,
    output logic [31:0]              issue_r2,
    output logic [ROB_WIDTH_BIT-1:0] issue_rob_id
);

    localparam int c_ENTRIES = 1 << RS_SIZE_BIT;

    logic [c_ENTRIES-1:0]     r_busy;
    logic [c_ENTRIES-1:0]     r_dep1;
    logic [c_ENTRIES-1:0]     r_dep2;
    logic [TYPE_BIT-1:0]      r_type [c_ENTRIES];
    logic [31:0]              r_v1   [c_ENTRIES];
    logic [31:0]              r_v2   [c_ENTRIES];
    logic [ROB_WIDTH_BIT-1:0] r_q1   [c_ENTRIES];
    logic [ROB_WIDTH_BIT-1:0] r_q2   [c_ENTRIES];
    logic [ROB_WIDTH_BIT-1:0] r_rob  [c_ENTRIES];

    logic [c_ENTRIES-1:0]     w_ready;
    logic                     w_sel_found;
    logic [RS_SIZE_BIT-1:0]   w_sel_idx;
    logic [RS_SIZE_BIT-1:0]   w_free_idx;
    logic                     w_ins_dep1;
    logic                     w_ins_dep2;
    logic [31:0]              w_ins_v1;
    logic [31:0]              w_ins_v2;

    assign full    = &r_busy;
    assign w_ready = r_busy & ~r_dep1 & ~r_dep2;

    // Descending scan so the lowest matching index is the one that sticks.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_free_idx  = '0;
        for (int i = c_ENTRIES - 1; i >= 0; i--) begin
            if (w_ready[i]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = RS_SIZE_BIT'(i);
            end
            if (!r_busy[i]) begin
                w_free_idx = RS_SIZE_BIT'(i);
            end
        end
    end

    // Same-cycle forwarding of a broadcast into the op being dispatched.
    always_comb begin
        w_ins_dep1 = in_has_dep1;
        w_ins_v1   = in_v1;
        w_ins_dep2 = in_has_dep2;
        w_ins_v2   = in_v2;
        if (in_has_dep1 && alu_cdb_ready && in_q1 == alu_cdb_rob_id) begin
            w_ins_dep1 = 1'b0;
            w_ins_v1   = alu_cdb_value;
        end else if (in_has_dep1 && lsb_cdb_ready && in_q1 == lsb_cdb_rob_id) begin
            w_ins_dep1 = 1'b0;
            w_ins_v1   = lsb_cdb_value;
        end
        if (in_has_dep2 && alu_cdb_ready && in_q2 == alu_cdb_rob_id) begin
            w_ins_dep2 = 1'b0;
            w_ins_v2   = alu_cdb_value;
        end else if (in_has_dep2 && lsb_cdb_ready && in_q2 == lsb_cdb_rob_id) begin
            w_ins_dep2 = 1'b0;
            w_ins_v2   = lsb_cdb_value;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_busy       <= '0;
            r_dep1       <= '0;
            r_dep2       <= '0;
            for (int i = 0; i < c_ENTRIES; i++) begin
                r_type[i] <= '0;
                r_v1[i]   <= '0;
                r_v2[i]   <= '0;
                r_q1[i]   <= '0;
                r_q2[i]   <= '0;
                r_rob[i]  <= '0;
            end
            issue_valid  <= 1'b0;
            issue_type   <= '0;
            issue_r1     <= '0;
            issue_r2     <= '0;
            issue_rob_id <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                r_busy      <= '0;
                issue_valid <= 1'b0;
            end else begin
                for (int i = 0; i < c_ENTRIES; i++) begin
                    if (r_busy[i] && r_dep1[i]) begin
                        if (alu_cdb_ready && r_q1[i] == alu_cdb_rob_id) begin
                            r_v1[i]   <= alu_cdb_value;
                            r_dep1[i] <= 1'b0;
                        end else if (lsb_cdb_ready && r_q1[i] == lsb_cdb_rob_id) begin
                            r_v1[i]   <= lsb_cdb_value;
                            r_dep1[i] <= 1'b0;
                        end
                    end
                    if (r_busy[i] && r_dep2[i]) begin
                        if (alu_cdb_ready && r_q2[i] == alu_cdb_rob_id) begin
                            r_v2[i]   <= alu_cdb_value;
                            r_dep2[i] <= 1'b0;
                        end else if (lsb_cdb_ready && r_q2[i] == lsb_cdb_rob_id) begin
                            r_v2[i]   <= lsb_cdb_value;
                            r_dep2[i] <= 1'b0;
                        end
                    end
                end
                // The free slot is never the issuing slot: one is busy pre-edge, the other not.
                if (in_valid && !full) begin
                    r_busy[w_free_idx] <= 1'b1;
                    r_type[w_free_idx] <= in_type;
                    r_v1[w_free_idx]   <= w_ins_v1;
                    r_v2[w_free_idx]   <= w_ins_v2;
                    r_dep1[w_free_idx] <= w_ins_dep1;
                    r_dep2[w_free_idx] <= w_ins_dep2;
                    r_q1[w_free_idx]   <= in_q1;
                    r_q2[w_free_idx]   <= in_q2;
                    r_rob[w_free_idx]  <= in_rob_id;
                end
                if (w_sel_found) begin
                    issue_valid         <= 1'b1;
                    issue_type          <= r_type[w_sel_idx];
                    issue_r1            <= r_v1[w_sel_idx];
                    issue_r2            <= r_v2[w_sel_idx];
                    issue_rob_id        <= r_rob[w_sel_idx];
                    r_busy[w_sel_idx]   <= 1'b0;
                end else begin
                    issue_valid <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_rs_scheduler.sv
`default_nettype none
// Testbench for alu_rs_scheduler: directed scenarios plus randomized traffic
// checked against a slot-level behavioural model of the reservation station.
module tb_alu_rs_scheduler;

    localparam int N = 8;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush, in_valid;
    logic [4:0]  in_type;
    logic [31:0] in_v1, in_v2;
    logic        in_has_dep1, in_has_dep2;
    logic [2:0]  in_q1, in_q2, in_rob_id;
    logic        full;
    logic        alu_cdb_ready, lsb_cdb_ready;
    logic [2:0]  alu_cdb_rob_id, lsb_cdb_rob_id;
    logic [31:0] alu_cdb_value, lsb_cdb_value;
    logic        issue_valid;
    logic [4:0]  issue_type;
    logic [31:0] issue_r1, issue_r2;
    logic [2:0]  issue_rob_id;

    int errors = 0;
    int checks = 0;

    alu_rs_scheduler #(.RS_SIZE_BIT(3), .ROB_WIDTH_BIT(3), .TYPE_BIT(5)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
        .in_valid(in_valid), .in_type(in_type),
        .in_v1(in_v1), .in_has_dep1(in_has_dep1), .in_q1(in_q1),
        .in_v2(in_v2), .in_has_dep2(in_has_dep2), .in_q2(in_q2),
        .in_rob_id(in_rob_id), .full(full),
        .alu_cdb_ready(alu_cdb_ready), .alu_cdb_rob_id(alu_cdb_rob_id), .alu_cdb_value(alu_cdb_value),
        .lsb_cdb_ready(lsb_cdb_ready), .lsb_cdb_rob_id(lsb_cdb_rob_id), .lsb_cdb_value(lsb_cdb_value),
        .issue_valid(issue_valid), .issue_type(issue_type),
        .issue_r1(issue_r1), .issue_r2(issue_r2), .issue_rob_id(issue_rob_id)
    );

    always #5 clk_in = ~clk_in;

    // ---------------- behavioural model ----------------
    typedef struct {
        bit        busy;
        bit [4:0]  typ;
        bit [31:0] v1, v2;
        bit        d1, d2;
        bit [2:0]  q1, q2, rob;
    } ent_t;

    ent_t        m [N];
    logic        e_iv;
    logic [4:0]  e_it;
    logic [31:0] e_r1, e_r2;
    logic [2:0]  e_rid;

    function automatic void model_reset();
        for (int i = 0; i < N; i++) m[i].busy = 1'b0;
        e_iv = 1'b0; e_it = '0; e_r1 = '0; e_r2 = '0; e_rid = '0;
    endfunction

    function automatic bit model_full();
        int cnt = 0;
        for (int i = 0; i < N; i++) cnt += int'(m[i].busy);
        return cnt == N;
    endfunction

    // Apply the broadcasts to one operand; ALU takes precedence.
    function automatic void resolve(input bit dep, input bit [2:0] q, input bit [31:0] v,
                                    output bit nd, output bit [31:0] nv);
        nd = dep; nv = v;
        if (dep && alu_cdb_ready && q == alu_cdb_rob_id) begin
            nd = 1'b0; nv = alu_cdb_value;
        end else if (dep && lsb_cdb_ready && q == lsb_cdb_rob_id) begin
            nd = 1'b0; nv = lsb_cdb_value;
        end
    endfunction

    function automatic void model_edge();
        int sel = -1;
        int fre = -1;
        if (!rdy_in) return;
        if (flush) begin
            for (int i = 0; i < N; i++) m[i].busy = 1'b0;
            e_iv = 1'b0;
            return;
        end
        for (int i = 0; i < N; i++) begin
            if (sel < 0 && m[i].busy && !m[i].d1 && !m[i].d2) sel = i;
            if (fre < 0 && !m[i].busy) fre = i;
        end
        if (sel >= 0) begin
            e_iv = 1'b1; e_it = m[sel].typ; e_r1 = m[sel].v1; e_r2 = m[sel].v2; e_rid = m[sel].rob;
            m[sel].busy = 1'b0;
        end else begin
            e_iv = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (m[i].busy) begin
                resolve(m[i].d1, m[i].q1, m[i].v1, m[i].d1, m[i].v1);
                resolve(m[i].d2, m[i].q2, m[i].v2, m[i].d2, m[i].v2);
            end
        end
        if (in_valid && fre >= 0) begin
            m[fre].busy = 1'b1; m[fre].typ = in_type; m[fre].rob = in_rob_id;
            m[fre].q1 = in_q1; m[fre].q2 = in_q2;
            resolve(in_has_dep1, in_q1, in_v1, m[fre].d1, m[fre].v1);
            resolve(in_has_dep2, in_q2, in_v2, m[fre].d2, m[fre].v2);
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        rdy_in = 1'b1; flush = 1'b0; in_valid = 1'b0; in_type = '0;
        in_v1 = '0; in_v2 = '0; in_has_dep1 = 1'b0; in_has_dep2 = 1'b0;
        in_q1 = '0; in_q2 = '0; in_rob_id = '0;
        alu_cdb_ready = 1'b0; alu_cdb_rob_id = '0; alu_cdb_value = '0;
        lsb_cdb_ready = 1'b0; lsb_cdb_rob_id = '0; lsb_cdb_value = '0;
    endtask

    task automatic tick();
        @(posedge clk_in);
        model_edge();
        #1;
    endtask

    task automatic put(input bit [4:0] t, input bit [31:0] v1, input bit d1, input bit [2:0] q1,
                       input bit [31:0] v2, input bit d2, input bit [2:0] q2, input bit [2:0] rob);
        in_valid = 1'b1; in_type = t; in_v1 = v1; in_has_dep1 = d1; in_q1 = q1;
        in_v2 = v2; in_has_dep2 = d2; in_q2 = q2; in_rob_id = rob;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle();
        rst_in = 1'b1;
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b0;
        model_reset();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", issue_valid); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
        checks++; if ({issue_type, issue_r1, issue_r2, issue_rob_id} !== 72'd0) begin
            errors++; $display("FAIL reset_fields: got %h want 0", {issue_type, issue_r1, issue_r2, issue_rob_id});
        end
    endtask

    task automatic test_basic_add();
        put(5'd0, 32'd5, 1'b0, 3'd0, 32'd7, 1'b0, 3'd0, 3'd2);
        tick(); idle();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL add_early: got %b want 0", issue_valid); end
        tick();
        checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b want 1", issue_valid); end
        checks++; if ({issue_type, issue_r1, issue_r2, issue_rob_id} !== {5'd0, 32'd5, 32'd7, 3'd2}) begin
            errors++; $display("FAIL add_fields: got t=%0d r1=%0d r2=%0d rob=%0d want 0/5/7/2",
                               issue_type, issue_r1, issue_r2, issue_rob_id);
        end
        tick();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL add_drop: got %b want 0", issue_valid); end
    endtask

    task automatic test_cdb_wakeup();
        put(5'h13, 32'd0, 1'b1, 3'd4, 32'd3, 1'b0, 3'd0, 3'd5);
        tick(); idle();
        repeat (2) begin
            tick();
            checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL wake_early: got %b want 0", issue_valid); end
        end
        alu_cdb_ready = 1'b1; alu_cdb_rob_id = 3'd4; alu_cdb_value = 32'hDEAD;
        tick(); idle();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL wake_same_edge: got %b want 0", issue_valid); end
        tick();
        checks++; if (issue_valid !== 1'b1 || issue_r1 !== 32'hDEAD || issue_r2 !== 32'd3 ||
                      issue_rob_id !== 3'd5 || issue_type !== 5'h13) begin
            errors++; $display("FAIL wake_issue: got v=%b t=%h r1=%h r2=%h rob=%0d want 1/13/dead/3/5",
                               issue_valid, issue_type, issue_r1, issue_r2, issue_rob_id);
        end
    endtask

    task automatic test_same_cycle_forward();
        put(5'h08, 32'd1, 1'b0, 3'd0, 32'd0, 1'b1, 3'd3, 3'd6);
        lsb_cdb_ready = 1'b1; lsb_cdb_rob_id = 3'd3; lsb_cdb_value = 32'd9;
        tick(); idle();
        tick();
        checks++; if (issue_valid !== 1'b1 || issue_r2 !== 32'd9 || issue_r1 !== 32'd1 || issue_rob_id !== 3'd6) begin
            errors++; $display("FAIL fwd_issue: got v=%b r1=%0d r2=%0d rob=%0d want 1/1/9/6",
                               issue_valid, issue_r1, issue_r2, issue_rob_id);
        end
        tick();
    endtask

    task automatic test_fill_full();
        for (int i = 0; i < N; i++) begin
            put(5'(i), 32'd0, 1'b1, 3'd1, 32'(i * 10), 1'b0, 3'd0, 3'(i));
            tick();
        end
        idle();
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b want 1", full); end
        put(5'd1, 32'd77, 1'b0, 3'd0, 32'd77, 1'b0, 3'd0, 3'd5);
        tick(); idle();
        alu_cdb_ready = 1'b1; alu_cdb_rob_id = 3'd1; alu_cdb_value = 32'h100;
        tick(); idle();
        for (int k = 0; k < N; k++) begin
            tick();
            checks++; if (issue_valid !== 1'b1 || issue_rob_id !== 3'(k) || issue_r1 !== 32'h100 ||
                          issue_r2 !== 32'(k * 10)) begin
                errors++; $display("FAIL fill_order%0d: got v=%b rob=%0d r1=%h r2=%0d want 1/%0d/100/%0d",
                                   k, issue_valid, issue_rob_id, issue_r1, issue_r2, k, k * 10);
            end
            if (k == 0) begin
                checks++; if (full !== 1'b0) begin errors++; $display("FAIL fill_full_drop: got %b want 0", full); end
            end
        end
        tick();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL fill_dropped_op: got %b want 0", issue_valid); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            put(5'd2, 32'd0, 1'b1, 3'd7, 32'd1, 1'b0, 3'd0, 3'(i));
            tick();
        end
        put(5'd0, 32'd4, 1'b0, 3'd0, 32'd4, 1'b0, 3'd0, 3'd3);
        flush = 1'b1;
        tick(); idle();
        checks++; if (issue_valid !== 1'b0 || full !== 1'b0) begin
            errors++; $display("FAIL flush_clear: got v=%b full=%b want 0/0", issue_valid, full);
        end
        alu_cdb_ready = 1'b1; alu_cdb_rob_id = 3'd7; alu_cdb_value = 32'd1;
        tick(); idle();
        repeat (2) begin
            tick();
            checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL flush_residue: got %b want 0", issue_valid); end
        end
    endtask

    task automatic test_rdy_hold();
        put(5'd4, 32'd0, 1'b1, 3'd2, 32'd8, 1'b0, 3'd0, 3'd3);
        tick();
        put(5'd5, 32'd11, 1'b0, 3'd0, 32'd12, 1'b0, 3'd0, 3'd1);
        tick(); idle();
        rdy_in = 1'b0;
        alu_cdb_ready = 1'b1; alu_cdb_rob_id = 3'd2; alu_cdb_value = 32'h55;
        for (int c = 0; c < 3; c++) begin
            tick();
            alu_cdb_ready = 1'b0;
            checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL pause_issue%0d: got %b want 0", c, issue_valid); end
        end
        idle();
        tick();
        checks++; if (issue_valid !== 1'b1 || issue_rob_id !== 3'd1 || issue_r1 !== 32'd11) begin
            errors++; $display("FAIL resume_issue: got v=%b rob=%0d r1=%0d want 1/1/11", issue_valid, issue_rob_id, issue_r1);
        end
        tick();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL pause_nowake: got %b want 0", issue_valid); end
        alu_cdb_ready = 1'b1; alu_cdb_rob_id = 3'd2; alu_cdb_value = 32'h66;
        tick(); idle();
        tick();
        checks++; if (issue_valid !== 1'b1 || issue_rob_id !== 3'd3 || issue_r1 !== 32'h66) begin
            errors++; $display("FAIL resume_wake: got v=%b rob=%0d r1=%h want 1/3/66", issue_valid, issue_rob_id, issue_r1);
        end
    endtask

    task automatic test_async_reset();
        put(5'd1, 32'd21, 1'b0, 3'd0, 32'd22, 1'b0, 3'd0, 3'd4);
        tick();
        put(5'd1, 32'd0, 1'b1, 3'd6, 32'd0, 1'b0, 3'd0, 3'd5);
        tick(); idle();
        checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL areset_pre: got %b want 1", issue_valid); end
        #3 rst_in = 1'b1;
        #1;
        checks++; if (issue_valid !== 1'b0 || {issue_type, issue_r1, issue_r2, issue_rob_id} !== 72'd0 || full !== 1'b0) begin
            errors++; $display("FAIL areset_now: got v=%b fields=%h full=%b want 0",
                               issue_valid, {issue_type, issue_r1, issue_r2, issue_rob_id}, full);
        end
        rst_in = 1'b0;
        model_reset();
        alu_cdb_ready = 1'b1; alu_cdb_rob_id = 3'd6; alu_cdb_value = 32'd1;
        tick(); idle();
        tick();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL areset_cleared: got %b want 0", issue_valid); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rdy_in        = ($urandom_range(0, 9) != 0);
            flush         = ($urandom_range(0, 39) == 0);
            in_valid      = ($urandom_range(0, 1) == 1);
            in_type       = 5'($urandom);
            in_v1         = $urandom;
            in_v2         = $urandom;
            in_has_dep1   = ($urandom_range(0, 1) == 1);
            in_has_dep2   = ($urandom_range(0, 2) == 0);
            in_q1         = 3'($urandom);
            in_q2         = 3'($urandom);
            in_rob_id     = 3'($urandom);
            alu_cdb_ready = ($urandom_range(0, 2) == 0);
            alu_cdb_rob_id = 3'($urandom);
            alu_cdb_value = $urandom;
            lsb_cdb_ready = ($urandom_range(0, 2) == 0);
            lsb_cdb_rob_id = 3'($urandom);
            lsb_cdb_value = $urandom;
            checks++; if (full !== model_full()) begin
                errors++; $display("FAIL rnd_full@%0d: got %b want %b", c, full, model_full());
            end
            tick();
            checks++; if (issue_valid !== e_iv) begin
                errors++; $display("FAIL rnd_valid@%0d: got %b want %b", c, issue_valid, e_iv);
            end
            checks++; if ({issue_type, issue_r1, issue_r2, issue_rob_id} !== {e_it, e_r1, e_r2, e_rid}) begin
                errors++; $display("FAIL rnd_fields@%0d: got t=%h r1=%h r2=%h rob=%0d want t=%h r1=%h r2=%h rob=%0d",
                                   c, issue_type, issue_r1, issue_r2, issue_rob_id, e_it, e_r1, e_r2, e_rid);
            end
        end
        idle();
    endtask

    initial begin
        rst_in = 1'b1;
        idle();
        model_reset();
        test_reset();
        test_basic_add();
        test_cdb_wakeup();
        test_same_cycle_forward();
        test_fill_full();
        test_flush();
        test_rdy_hold();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
